d_branch_ctrl: RTL
==================

// Module: d_branch_ctrl
// PURPOSE
//  D-stage branch sequencer wrapped around the branch comparator (zero = Rs==Rt, ovf = signed Rs+Rt overflow).
//  Holds a branch in D until its forwarded operands are final, resolves it, and issues a registered
//  redirect to the fetch stage with a valid/ack handshake. Keeps saturating branch/taken statistics and a
//  sticky error flag for operand-wait timeouts.
// PARAMETERS
//  CNT_W     16  width of statistics counters (saturate at all-ones)
//  MAX_WAIT  8   max consecutive WAIT cycles before err_timeout is set
// PORTS
//  clk             in   1   clock, rising edge
//  reset           in   1   asynchronous, active-low reset
//  D_valid         in   1   D-stage instruction valid
//  D_br_type       in   2   00 none, 01 beq, 10 bne, 11 bovf (taken if Rs+Rt overflows)
//  D_pc            in   32  PC of the D-stage instruction
//  D_imm           in   16  branch offset (words, signed)
//  D_opnd_ready    in   1   Rs/Rt forwarding final this cycle
//  cmp_zero        in   1   comparator equal flag
//  cmp_ovf         in   1   comparator overflow flag
//  F_redirect_ack  in   1   fetch consumed redirect this cycle
//  D_stall         out  1   hold F/D registers
//  redirect_valid  out  1   registered; fetch must load redirect_pc
//  redirect_pc     out  32  registered branch target
//  stat_branches   out  CNT_W  resolved branches
//  stat_taken      out  CNT_W  resolved taken branches
//  err_timeout     out  1   sticky: WAIT exceeded MAX_WAIT
// BEHAVIOUR
//  Reset (async, low): state=IDLE, redirect_valid=0, redirect_pc=0, stats=0, err_timeout=0, wait_cnt=0.
//  is_br = D_valid & (D_br_type!=00). taken: beq=cmp_zero, bne=~cmp_zero, bovf=cmp_ovf.
//  target = D_pc + 4 + {{14{D_imm[15]}},D_imm,2'b00}; 32-bit wrap-around, no overflow detection.
//  pend_busy = redirect_valid & ~F_redirect_ack.
//  resolve = is_br & D_opnd_ready & ~pend_busy (IDLE or WAIT).
//  FSM states:
//   IDLE: is_br & ~resolve -> WAIT, wait_cnt=1. resolve -> stay IDLE.
//   WAIT: resolve -> IDLE, wait_cnt=0; ~is_br (flushed/killed) -> IDLE; else wait_cnt++ (saturate);
//         wait_cnt==MAX_WAIT while staying -> err_timeout<=1 (sticky until reset).
//  D_stall = is_br & ~resolve (combinational; 0 when not a branch).
//  On resolve: stat_branches++ (sat); if taken: stat_taken++ (sat), redirect_valid<=1, redirect_pc<=target
//   -> latency 1 cycle from resolve edge to redirect_valid. Not taken: no redirect (delay slot + fall-through).
//  redirect_valid clears on F_redirect_ack unless a taken resolve loads a new one in the same cycle
//   (new wins; pc replaced). Ack with redirect_valid=0 ignored.
//  A branch never resolves while an older redirect is unacked (stalls instead).
//  Reset mid-WAIT or with pending redirect: everything cleared immediately; no redirect issued.
// STRUCTURE
//  Shared pkg/defines: BR_NONE/BEQ/BNE/BOVF codes, ST_IDLE/ST_WAIT encodings.
//  One sub-module: sat_counter (param width, inc, clk, reset) instanced for both statistics counters.
//  Taken logic and target adder are inline combinational; FSM + redirect register in one always block.
// TESTING
//  1 beq, pc=0x3000, imm=0x0004, zero=1, ready=1 -> next cycle redirect_valid=1, pc=0x3014; stall=0.
//  2 bne, zero=1 -> no redirect; stat_branches=1, stat_taken=0; D_stall=0.
//  3 beq ready=0 for 3 cycles then 1 -> D_stall=1 x3, state WAIT, resolves 4th cycle, redirect next.
//  4 bovf imm=0xFFFF, pc=0x3000, ovf=1 -> redirect_pc=0x3000; err path: ready held 0 for 9 cycles -> err_timeout=1.
//  5 redirect pending, no ack, new taken branch -> D_stall=1 until ack; ack+new resolve same cycle -> new pc.
//  6 reset low during WAIT with redirect_valid=1 -> all outputs 0 at once; stats saturate at 0xFFFF check.

Source files
------------

// File: rtl/d_branch_ctrl_pkg.sv
// Shared branch-type codes, FSM state encoding and the branch target helper
// for the D-stage branch controller.
package d_branch_ctrl_pkg;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BEQ  = 2'b01;
  localparam logic [1:0] BR_BNE  = 2'b10;
  localparam logic [1:0] BR_BOVF = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // Word offset relative to the delay-slot PC; 32-bit wrap-around is intended.
  function automatic logic [31:0] br_target(input logic [31:0] pc, input logic [15:0] imm);
    return pc + 32'd4 + {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/d_branch_ctrl_sat_counter.sv
// Saturating up-counter with asynchronous active-low reset; holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/d_branch_ctrl.sv
// D-stage branch sequencer: holds a branch until operands are final, resolves it
// and issues a registered redirect to fetch (redirect_valid held until F_redirect_ack).
module d_branch_ctrl
  import d_branch_ctrl_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             D_valid,
  input  logic [1:0]       D_br_type,
  input  logic [31:0]      D_pc,
  input  logic [15:0]      D_imm,
  input  logic             D_opnd_ready,
  input  logic             cmp_zero,
  input  logic             cmp_ovf,
  input  logic             F_redirect_ack,
  output logic             D_stall,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_taken,
  output logic             err_timeout,
  output state_e           dbg_state
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              err_q, err_d;
  logic              rv_q, rv_d;
  logic [31:0]       rpc_q, rpc_d;

  logic        is_br;
  logic        taken;
  logic        pend_busy;
  logic        resolve;
  logic [31:0] target;

  assign is_br     = D_valid && (D_br_type != BR_NONE);
  assign pend_busy = rv_q && !F_redirect_ack;
  assign resolve   = is_br && D_opnd_ready && !pend_busy;
  assign target    = br_target(D_pc, D_imm);

  always_comb begin
    taken = 1'b0;
    case (D_br_type)
      BR_BEQ:  taken = cmp_zero;
      BR_BNE:  taken = !cmp_zero;
      BR_BOVF: taken = cmp_ovf;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    rv_d       = rv_q;
    rpc_d      = rpc_q;
    case (state_q)
      ST_IDLE: begin
        if (is_br && !resolve) begin
          state_d    = ST_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      ST_WAIT: begin
        // A killed/flushed branch abandons the wait without resolving.
        if (resolve || !is_br) begin
          state_d    = ST_IDLE;
          wait_cnt_d = '0;
        end else begin
          if (wait_cnt_q == MAX_WAIT_C) err_d = 1'b1;
          if (wait_cnt_q != '1) wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A new taken branch overrides a redirect being acknowledged this cycle.
    if (resolve && taken) begin
      rv_d  = 1'b1;
      rpc_d = target;
    end else if (F_redirect_ack) begin
      rv_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
      rv_q       <= 1'b0;
      rpc_q      <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
      rv_q       <= rv_d;
      rpc_q      <= rpc_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt_branches (
    .clk   (clk),
    .reset (reset),
    .inc   (resolve),
    .cnt   (stat_branches)
  );

  sat_counter #(.W(CNT_W)) u_cnt_taken (
    .clk   (clk),
    .reset (reset),
    .inc   (resolve && taken),
    .cnt   (stat_taken)
  );

  assign D_stall        = is_br && !resolve;
  assign redirect_valid = rv_q;
  assign redirect_pc    = rpc_q;
  assign err_timeout    = err_q;
  assign dbg_state      = state_q;

endmodule
